// File: rtl/ttt_game_core.sv
// rtl/ttt_game_core.sv - N x N, K-in-a-row board game engine
// Owns the board, turn and move legality; win/draw is found by a sequential 4-direction scan.
module ttt_game_core #(
  parameter int N  = 3,
  parameter int K  = 3,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          new_game,
  input  logic          move_valid,
  input  logic [CW-1:0] move_row,
  input  logic [CW-1:0] move_col,
  output logic          move_ready,
  output logic          illegal,
  output logic          in_main,
  output logic          turn_o,
  output logic [1:0]    winner,
  output logic          game_over,
  output logic [7:0]    move_count,
  input  logic [CW-1:0] rd_row,
  input  logic [CW-1:0] rd_col,
  output logic [1:0]    rd_cell
);

  localparam int CELLS = N * N;
  localparam int IW    = $clog2(CELLS);
  localparam int SW    = CW + 2;
  localparam int OW    = CW + 1;

  typedef enum logic [1:0] {S_MAIN, S_PLAY, S_CHECK, S_OVER} state_t;

  state_t         state_q, state_d;
  logic [1:0]     board_q [CELLS];
  logic [1:0]     board_d [CELLS];
  logic           turn_q, turn_d;
  logic [1:0]     winner_q, winner_d;
  logic [7:0]     count_q, count_d;
  logic           illegal_q, illegal_d;
  logic [CW-1:0]  mrow_q, mrow_d, mcol_q, mcol_d;
  logic [1:0]     dir_q, dir_d;
  logic [OW-1:0]  off_q, off_d, run_q, run_d;
  logic           win_q, win_d;

  logic [1:0]        mark;
  logic              mv_inb, mv_free, sc_inb, sc_hit, last_ofs, rd_inb, win_nx;
  logic [IW-1:0]     mv_idx, sc_idx, rd_idx;
  logic signed [SW-1:0] ofs, base_r, base_c, sc_row, sc_col;
  logic [OW-1:0]     run_nx;

  always_comb begin
    mark    = turn_q ? 2'd2 : 2'd1;
    mv_inb  = ({1'b0, move_row} < OW'(N)) && ({1'b0, move_col} < OW'(N));
    mv_idx  = mv_inb ? IW'(int'(move_row) * N + int'(move_col)) : '0;
    mv_free = mv_inb && (board_q[mv_idx] == 2'd0);

    // Scan cell = latched move + offset along the current direction
    ofs    = $signed({1'b0, off_q}) - $signed(SW'(K - 1));
    base_r = $signed({2'b00, mrow_q});
    base_c = $signed({2'b00, mcol_q});
    sc_row = base_r;
    sc_col = base_c;
    case (dir_q)
      2'd0: sc_col = base_c + ofs;
      2'd1: sc_row = base_r + ofs;
      2'd2: begin sc_row = base_r + ofs; sc_col = base_c + ofs; end
      default: begin sc_row = base_r + ofs; sc_col = base_c - ofs; end
    endcase
    sc_inb   = !sc_row[SW-1] && !sc_col[SW-1] &&
               (sc_row < $signed(SW'(N))) && (sc_col < $signed(SW'(N)));
    sc_idx   = sc_inb ? IW'(int'(sc_row) * N + int'(sc_col)) : '0;
    sc_hit   = sc_inb && (board_q[sc_idx] == mark);
    run_nx   = sc_hit ? run_q + 1'b1 : '0;
    win_nx   = win_q | (run_nx >= OW'(K));
    last_ofs = (off_q == OW'(2 * K - 2));

    rd_inb  = ({1'b0, rd_row} < OW'(N)) && ({1'b0, rd_col} < OW'(N));
    rd_idx  = rd_inb ? IW'(int'(rd_row) * N + int'(rd_col)) : '0;
    rd_cell = rd_inb ? board_q[rd_idx] : 2'd0;
  end

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    turn_d    = turn_q;
    winner_d  = winner_q;
    count_d   = count_q;
    illegal_d = 1'b0;
    mrow_d    = mrow_q;
    mcol_d    = mcol_q;
    dir_d     = dir_q;
    off_d     = off_q;
    run_d     = run_q;
    win_d     = win_q;
    if (new_game) begin
      for (int i = 0; i < CELLS; i++) board_d[i] = 2'd0;
      turn_d   = 1'b0;
      winner_d = 2'd0;
      count_d  = 8'd0;
      dir_d    = 2'd0;
      off_d    = '0;
      run_d    = '0;
      win_d    = 1'b0;
      state_d  = S_PLAY;
    end else begin
      case (state_q)
        S_MAIN: if (start) state_d = S_PLAY;
        S_PLAY: begin
          if (move_valid) begin
            if (mv_free) begin
              board_d[mv_idx] = mark;
              count_d = count_q + 8'd1;
              mrow_d  = move_row;
              mcol_d  = move_col;
              dir_d   = 2'd0;
              off_d   = '0;
              run_d   = '0;
              win_d   = 1'b0;
              state_d = S_CHECK;
            end else begin
              illegal_d = 1'b1;
            end
          end
        end
        S_CHECK: begin
          win_d = win_nx;
          run_d = last_ofs ? '0 : run_nx;
          off_d = last_ofs ? '0 : off_q + 1'b1;
          if (last_ofs) dir_d = dir_q + 2'd1;
          if (last_ofs && dir_q == 2'd3) begin
            if (win_nx) begin
              winner_d = mark;
              state_d  = S_OVER;
            end else if (count_q == 8'(CELLS)) begin
              winner_d = 2'd3;
              state_d  = S_OVER;
            end else begin
              turn_d  = ~turn_q;
              state_d = S_PLAY;
            end
          end
        end
        S_OVER: state_d = S_OVER;
        default: state_d = S_MAIN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_MAIN;
      for (int i = 0; i < CELLS; i++) board_q[i] <= 2'd0;
      turn_q    <= 1'b0;
      winner_q  <= 2'd0;
      count_q   <= 8'd0;
      illegal_q <= 1'b0;
      mrow_q    <= '0;
      mcol_q    <= '0;
      dir_q     <= 2'd0;
      off_q     <= '0;
      run_q     <= '0;
      win_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      turn_q    <= turn_d;
      winner_q  <= winner_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
      mrow_q    <= mrow_d;
      mcol_q    <= mcol_d;
      dir_q     <= dir_d;
      off_q     <= off_d;
      run_q     <= run_d;
      win_q     <= win_d;
    end
  end

  assign move_ready = (state_q == S_PLAY);
  assign in_main    = (state_q == S_MAIN);
  assign game_over  = (state_q == S_OVER);
  assign illegal    = illegal_q;
  assign turn_o     = turn_q;
  assign winner     = winner_q;
  assign move_count = count_q;

endmodule

// File: tb/tb_ttt_game_core.sv
// tb/tb_ttt_game_core.sv - scoreboard bench for ttt_game_core
// Instance 0 is N=3,K=3; instance 1 is N=5,K=4; expectations come from a full-board software model.
module tb_ttt_game_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i [2];
  logic       ng_i    [2];
  logic       mv_i    [2];
  logic [3:0] mrow_i  [2];
  logic [3:0] mcol_i  [2];
  logic [3:0] rdr_i   [2];
  logic [3:0] rdc_i   [2];
  logic       mr_o    [2];
  logic       ill_o   [2];
  logic       main_o  [2];
  logic       t_o     [2];
  logic [1:0] win_o   [2];
  logic       go_o    [2];
  logic [7:0] cnt_o   [2];
  logic [1:0] cell_o  [2];

  always #5 clk = ~clk;

  ttt_game_core #(.N(3), .K(3), .CW(4)) dut3 (
    .clk(clk), .rst(rst), .start(start_i[0]), .new_game(ng_i[0]),
    .move_valid(mv_i[0]), .move_row(mrow_i[0]), .move_col(mcol_i[0]),
    .move_ready(mr_o[0]), .illegal(ill_o[0]), .in_main(main_o[0]),
    .turn_o(t_o[0]), .winner(win_o[0]), .game_over(go_o[0]),
    .move_count(cnt_o[0]), .rd_row(rdr_i[0]), .rd_col(rdc_i[0]), .rd_cell(cell_o[0]));

  ttt_game_core #(.N(5), .K(4), .CW(4)) dut5 (
    .clk(clk), .rst(rst), .start(start_i[1]), .new_game(ng_i[1]),
    .move_valid(mv_i[1]), .move_row(mrow_i[1]), .move_col(mcol_i[1]),
    .move_ready(mr_o[1]), .illegal(ill_o[1]), .in_main(main_o[1]),
    .turn_o(t_o[1]), .winner(win_o[1]), .game_over(go_o[1]),
    .move_count(cnt_o[1]), .rd_row(rdr_i[1]), .rd_col(rdc_i[1]), .rd_cell(cell_o[1]));

  typedef struct {
    int ill;
    int win;
    int over;
    int turn;
    int cnt;
    int ready;
  } exp_t;

  exp_t sb_q [$];
  int n_cmp = 0;
  int n_err = 0;

  int mb [2][15][15];
  int mturn [2];
  int mcnt  [2];
  int mwin  [2];
  int mover [2];

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset(input int w);
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 15; c++) mb[w][r][c] = 0;
    mturn[w] = 0; mcnt[w] = 0; mwin[w] = 0; mover[w] = 0;
  endtask

  function automatic int model_win(input int w, input int n, input int k, input int m);
    int dr [4] = '{0, 1, 1, 1};
    int dc [4] = '{1, 0, 1, -1};
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        for (int d = 0; d < 4; d++) begin
          int hits = 0;
          for (int i = 0; i < k; i++) begin
            int rr = r + dr[d] * i;
            int cc = c + dc[d] * i;
            if (rr >= 0 && rr < n && cc >= 0 && cc < n && mb[w][rr][cc] == m) hits++;
          end
          if (hits == k) return 1;
        end
    return 0;
  endfunction

  task automatic push_state(input int w, input int ill, input int ready);
    exp_t e;
    e.ill = ill; e.win = mwin[w]; e.over = mover[w];
    e.turn = mturn[w]; e.cnt = mcnt[w]; e.ready = ready;
    sb_q.push_back(e);
  endtask

  task automatic compare_state(input int w, input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_winner"},    int'(win_o[w]), e.win);
    check({tag, "_game_over"}, int'(go_o[w]),  e.over);
    check({tag, "_turn"},      int'(t_o[w]),   e.turn);
    check({tag, "_count"},     int'(cnt_o[w]), e.cnt);
    check({tag, "_ready"},     int'(mr_o[w]),  e.ready);
  endtask

  task automatic read_cell(input int w, input int r, input int c, output int v);
    rdr_i[w] = 4'(r);
    rdc_i[w] = 4'(c);
    #1 v = int'(cell_o[w]);
  endtask

  task automatic pulse_new(input int w);
    @(negedge clk) ng_i[w] = 1'b1;
    @(posedge clk) #1 ng_i[w] = 1'b0;
    model_reset(w);
  endtask

  task automatic do_move(input int w, input int r, input int c, input string tag);
    int n, k, len, m, legal, ill, v;
    n = (w != 0) ? 5 : 3;
    k = (w != 0) ? 4 : 3;
    len = 4 * (2 * k - 1);
    legal = 0; ill = 0; m = (mturn[w] != 0) ? 2 : 1;
    if (mover[w] != 0) begin
      ill = 0;
    end else if (r >= n || c >= n || mb[w][r][c] != 0) begin
      ill = 1;
    end else begin
      legal = 1;
      mb[w][r][c] = m;
      mcnt[w]++;
      if (model_win(w, n, k, m) != 0) begin
        mwin[w] = m; mover[w] = 1;
      end else if (mcnt[w] == n * n) begin
        mwin[w] = 3; mover[w] = 1;
      end else begin
        mturn[w] = 1 - mturn[w];
      end
    end
    push_state(w, ill, (mover[w] != 0) ? 0 : 1);

    @(negedge clk);
    mv_i[w] = 1'b1; mrow_i[w] = 4'(r); mcol_i[w] = 4'(c);
    @(posedge clk) #1 mv_i[w] = 1'b0;
    @(negedge clk);
    check({tag, "_illegal"}, int'(ill_o[w]), sb_q[sb_q.size() - 1].ill);
    if (legal != 0) begin
      read_cell(w, r, c, v);
      check({tag, "_cell"}, v, m);
      check({tag, "_busy0"}, int'(mr_o[w]), 0);
      repeat (len - 1) @(posedge clk);
      @(negedge clk);
      check({tag, "_busy_last"}, int'(mr_o[w]), 0);
      @(posedge clk);
      @(negedge clk);
    end else begin
      @(negedge clk);
      check({tag, "_illegal_end"}, int'(ill_o[w]), 0);
    end
    compare_state(w, tag);
  endtask

  int v;

  initial begin
    for (int w = 0; w < 2; w++) begin
      start_i[w] = 1'b0; ng_i[w] = 1'b0; mv_i[w] = 1'b0;
      mrow_i[w] = '0; mcol_i[w] = '0; rdr_i[w] = '0; rdc_i[w] = '0;
      model_reset(w);
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_main", int'(main_o[0]), 1);
    check("rst_ready", int'(mr_o[0]), 0);
    check("rst_game_over", int'(go_o[0]), 0);
    check("rst_illegal", int'(ill_o[0]), 0);
    push_state(0, 0, 0);
    compare_state(0, "rst");
    rst = 1'b0;

    @(negedge clk);
    start_i[0] = 1'b1; start_i[1] = 1'b1;
    @(posedge clk) #1;
    start_i[0] = 1'b0; start_i[1] = 1'b0;
    @(negedge clk);
    check("start_in_main", int'(main_o[0]), 0);
    read_cell(0, 1, 1, v);
    check("start_cell11", v, 0);
    push_state(0, 0, 1);
    compare_state(0, "start");

    do_move(0, 0, 0, "w_x00");
    do_move(0, 1, 0, "w_o10");
    do_move(0, 0, 1, "w_x01");
    do_move(0, 1, 1, "w_o11");
    do_move(0, 0, 2, "w_x02");
    do_move(0, 2, 2, "w_after_over");

    pulse_new(0);
    do_move(0, 0, 0, "i_x00");
    do_move(0, 0, 0, "i_occupied");
    do_move(0, 3, 1, "i_offboard");
    read_cell(0, 3, 1, v);
    check("offboard_read", v, 0);

    pulse_new(0);
    do_move(0, 0, 0, "d1");
    do_move(0, 0, 1, "d2");
    do_move(0, 0, 2, "d3");
    do_move(0, 1, 1, "d4");
    do_move(0, 1, 0, "d5");
    do_move(0, 1, 2, "d6");
    do_move(0, 2, 1, "d7");
    do_move(0, 2, 0, "d8");
    do_move(0, 2, 2, "d9");

    do_move(1, 0, 0, "g1");
    do_move(1, 0, 3, "g2");
    do_move(1, 4, 4, "g3");
    do_move(1, 1, 2, "g4");
    do_move(1, 4, 2, "g5");
    do_move(1, 2, 1, "g6");
    do_move(1, 2, 4, "g7");
    do_move(1, 3, 0, "g8");

    pulse_new(0);
    @(negedge clk);
    mv_i[0] = 1'b1; mrow_i[0] = 4'd1; mcol_i[0] = 4'd1;
    @(posedge clk) #1 mv_i[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1 check("ng_still_check", int'(mr_o[0]), 0);
    ng_i[0] = 1'b1;
    @(posedge clk) #1 ng_i[0] = 1'b0;
    model_reset(0);
    @(negedge clk);
    read_cell(0, 1, 1, v);
    check("ng_cell11", v, 0);
    push_state(0, 0, 1);
    compare_state(0, "ng_mid_check");

    pulse_new(1);
    @(negedge clk);
    mv_i[1] = 1'b1; mrow_i[1] = 4'd2; mcol_i[1] = 4'd2;
    @(posedge clk) #1 mv_i[1] = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    model_reset(1);
    check("rst_mid_in_main", int'(main_o[1]), 1);
    check("rst_mid_illegal", int'(ill_o[1]), 0);
    read_cell(1, 2, 2, v);
    check("rst_mid_cell22", v, 0);
    push_state(1, 0, 0);
    compare_state(1, "rst_mid");
    @(negedge clk) rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
